// File: rtl/serial_sub_n.sv
// Multi-cycle ripple-borrow subtractor: d = a - b - bin, BPC bits per cycle, LSB slice first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_n #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int K  = (BPC > 0) ? WIDTH / BPC : 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (WIDTH < 2 || BPC < 1 || (BPC > 0 && (WIDTH % BPC) != 0)) begin : g_bad_param
      $error("serial_sub_n: WIDTH must be >= 2 and BPC must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     res_sh;
  logic                 borrow;
  logic [BPC-1:0]       slice_d;
  logic                 slice_b;
  logic [WIDTH+BPC-1:0] res_cat;
  logic [WIDTH-1:0]     res_nxt;
  logic                 last;
  logic                 accept;
`ifdef SERIAL_SUB_OVF_EN
  logic                 a_msb;
  logic                 b_msb;
`endif

  // Full-subtractor chain across one slice; returns {final borrow, difference bits}.
  function automatic logic [BPC:0] sub_slice(input logic [BPC-1:0] x,
                                             input logic [BPC-1:0] y,
                                             input logic           cin);
    logic [BPC-1:0] diff;
    logic           c;
    c    = cin;
    diff = '0;
    for (int j = 0; j < BPC; j++) begin
      diff[j] = x[j] ^ y[j] ^ c;
      c       = (~x[j] & y[j]) | (~(x[j] ^ y[j]) & c);
    end
    return {c, diff};
  endfunction

  always_comb begin
    {slice_b, slice_d} = sub_slice(a_sh[BPC-1:0], b_sh[BPC-1:0], borrow);
    res_cat            = {slice_d, res_sh};
    res_nxt            = res_cat[WIDTH+BPC-1:BPC];
    last               = (cnt == CW'(K - 1));
    accept             = (state == IDLE) && start;
  end

  // Control and registered outputs: cleared by reset, partial work is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            d     <= res_nxt;
            bout  <= slice_b;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
`endif
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand/result shift path: every bit is rewritten before it is used, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> BPC;
      b_sh   <= b_sh >> BPC;
      borrow <= slice_b;
      res_sh <= res_nxt;
    end
  end

endmodule
